e_variant_sequencer: RTL and testbench

Upstream stimulus stage for the match-counter block: steps through enum variant codes, driving each onto the variant input of the downstream matcher.
- Holds each code under a valid/ready handshake.
- Emits alongside each code the result value the matcher must produce, for an in-line checker.
- Counts completed passes over all variants and stops after a programmed number of passes.

---
 rtl/e_variant_sequencer_pkg.sv | 26 ++
 rtl/e_variant_sequencer_if.sv | 21 ++
 rtl/e_expected_lut.sv | 14 +
 rtl/e_variant_sequencer.sv | 110 +++++++++++
 tb/tb_e_variant_sequencer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/e_variant_sequencer_pkg.sv
// Shared definitions for the variant sequencer and its downstream checker.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
// Contents: FSM state encoding, packed result field offsets, variant->expected map.
package e_variant_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int OUT_W        = 26;
  localparam int VARIANT_LSB  = 0;
  localparam int EXPECTED_LSB = 8;
  localparam int COUNT_LSB    = 16;
  localparam int VALID_BIT    = 24;
  localparam int DONE_BIT     = 25;

  // Matcher contract: code 0 yields 0, any other code v yields v+1 (8-bit wrap).
  function automatic logic [7:0] expected_of(input logic [7:0] variant);
    return (variant == 8'd0) ? 8'd0 : variant + 8'd1;
  endfunction

endpackage

// File: rtl/e_variant_sequencer_if.sv
// Handshake bundle between the variant sequencer and the downstream matcher.
// Latency: none (wires only).
// Backpressure: _i_ready from the matcher stalls the sequencer while valid is high.
// Members: _i_start (run launch), _i_ready (accept), __output (packed 26-bit result).
interface e_variant_sequencer_if;
  logic        _i_start;
  logic        _i_ready;
  logic [25:0] __output;

  modport master (
    input  _i_start,
    input  _i_ready,
    output __output
  );

  modport slave (
    output _i_start,
    output _i_ready,
    input  __output
  );
endinterface

// File: rtl/e_expected_lut.sv
// Combinational variant->expected map, shared with the downstream checker.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: variant (8-bit code in), expected (8-bit matcher result out).
module e_expected_lut
  import e_variant_sequencer_pkg::*;
(
  input  logic [7:0] variant,
  output logic [7:0] expected
);

  assign expected = expected_of(variant);

endmodule

// File: rtl/e_variant_sequencer.sv
// Steps variant codes 0..NUM_VARIANTS-1 to the matcher, tagging each with its expected result.
// Latency: valid rises one cycle after start is sampled; HOLD_CYCLES low cycles after each accept.
// Backpressure: holds code/expected steady with valid high until _i_ready; ready ignored when valid low.
// Ports: _i_clk, _i_rst (sync, active-high), bus (master: _i_start, _i_ready in; __output out).
module e_variant_sequencer
  import e_variant_sequencer_pkg::*;
#(
  parameter int NUM_VARIANTS = 3,
  parameter int HOLD_CYCLES  = 1,
  parameter int REPEAT       = 1
) (
  input  logic             _i_clk,
  input  logic             _i_rst,
  e_variant_sequencer_if.master bus
);

  // Counter holds HOLD_CYCLES-1 at most; keep at least one bit so the
  // declaration stays legal when holding is disabled.
  localparam int          HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [7:0]  LAST      = 8'(NUM_VARIANTS - 1);
  localparam logic [7:0]  REPEAT_W  = 8'(REPEAT);

  state_t          state, state_n;
  logic [7:0]      variant, variant_n;
  logic [7:0]      pass_count, pass_n;
  logic [HW-1:0]   hold_cnt, hold_n;
  logic            advance;
  logic [7:0]      expected;
  logic [OUT_W-1:0] out;

  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      state      <= IDLE;
      variant    <= 8'd0;
      pass_count <= 8'd0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      variant    <= variant_n;
      pass_count <= pass_n;
      hold_cnt   <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    variant_n = variant;
    pass_n    = pass_count;
    hold_n    = hold_cnt;
    advance   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (bus._i_start) begin
          state_n   = EMIT;
          variant_n = 8'd0;
          pass_n    = 8'd0;
        end
      end
      EMIT: begin
        if (bus._i_ready) begin
          if (HOLD_CYCLES > 0) begin
            state_n = HOLD;
            hold_n  = HOLD_LOAD;
          end else begin
            advance = 1'b1;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          advance = 1'b1;
        end else begin
          hold_n = hold_cnt - HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // variant never exceeds LAST, so inequality is enough to detect "not last".
    if (advance) begin
      if (variant != LAST) begin
        variant_n = variant + 8'd1;
        state_n   = EMIT;
      end else begin
        variant_n = 8'd0;
        pass_n    = pass_count + 8'd1;
        state_n   = ((REPEAT != 0) && (pass_n == REPEAT_W)) ? DONE : EMIT;
      end
    end
  end

  e_expected_lut u_lut (
    .variant  (variant),
    .expected (expected)
  );

  always_comb begin
    out                          = '0;
    out[VARIANT_LSB  +: 8]       = variant;
    out[EXPECTED_LSB +: 8]       = expected;
    out[COUNT_LSB    +: 8]       = pass_count;
    out[VALID_BIT]               = (state == EMIT);
    out[DONE_BIT]                = (state == DONE);
  end

  assign bus.__output = out;

endmodule

// File: tb/tb_e_variant_sequencer.sv
// Bench for e_variant_sequencer: three parameterisations, queue scoreboard per instance.
// Expected code stream per run is derived from the pass/variant rules and checked on handshakes.
module tb_e_variant_sequencer;

  localparam int NA = 3, HA = 1, RA = 1;
  localparam int NB = 3, HB = 0, RB = 2;
  localparam int NC = 1, HC = 0, RC = 0;

  typedef struct packed {
    logic [7:0] pass;
    logic [7:0] expected;
    logic [7:0] variant;
  } item_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   vectors = 0;
  int   miscompares = 0;
  item_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  e_variant_sequencer_if ia_if ();
  e_variant_sequencer_if ib_if ();
  e_variant_sequencer_if ic_if ();

  e_variant_sequencer #(.NUM_VARIANTS(NA), .HOLD_CYCLES(HA), .REPEAT(RA)) dut_a (
    ._i_clk (clk), ._i_rst (rst_a), .bus (ia_if));
  e_variant_sequencer #(.NUM_VARIANTS(NB), .HOLD_CYCLES(HB), .REPEAT(RB)) dut_b (
    ._i_clk (clk), ._i_rst (rst_b), .bus (ib_if));
  e_variant_sequencer #(.NUM_VARIANTS(NC), .HOLD_CYCLES(HC), .REPEAT(RC)) dut_c (
    ._i_clk (clk), ._i_rst (rst_c), .bus (ic_if));

  function automatic logic [7:0] exp_of(input int v);
    return (v == 0) ? 8'd0 : 8'(v + 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [25:0] out_of(input int w);
    case (w)
      0:       return ia_if.__output;
      1:       return ib_if.__output;
      default: return ic_if.__output;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    logic [25:0] o;
    o = out_of(w);
    return o[25];
  endfunction

  task automatic set_ready(input int w, input logic v);
    case (w)
      0:       ia_if._i_ready = v;
      1:       ib_if._i_ready = v;
      default: ic_if._i_ready = v;
    endcase
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      0:       ia_if._i_start = v;
      1:       ib_if._i_start = v;
      default: ic_if._i_start = v;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int w);
    set_start(w, 1'b1);
    tick();
    set_start(w, 1'b0);
  endtask

  // Reference: a run emits `passes` passes of codes 0..n-1; pass_count is the
  // number of completed passes at the time each code is offered.
  task automatic push_run(input int w, input int passes, input int n);
    item_t it;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < n; v++) begin
        it.pass     = 8'(p);
        it.expected = exp_of(v);
        it.variant  = 8'(v);
        case (w)
          0:       qa.push_back(it);
          1:       qb.push_back(it);
          default: qc.push_back(it);
        endcase
      end
    end
  endtask

  task automatic sb_pop(input int w, input logic [25:0] o);
    item_t it;
    logic  got;
    got = 1'b0;
    it  = '0;
    case (w)
      0:       if (qa.size() > 0) begin it = qa.pop_front(); got = 1'b1; end
      1:       if (qb.size() > 0) begin it = qb.pop_front(); got = 1'b1; end
      default: if (qc.size() > 0) begin it = qc.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL sb%0d_unexpected: got code %0d, required no handshake", w, o[7:0]);
    end else begin
      check($sformatf("sb%0d_variant", w),  o[7:0],   it.variant);
      check($sformatf("sb%0d_expected", w), o[15:8],  it.expected);
      check($sformatf("sb%0d_pass", w),     o[23:16], it.pass);
    end
  endtask

  // Monitor: every accepted code is compared against the scoreboard head.
  always @(negedge clk) begin
    if (ia_if.__output[24] && ia_if._i_ready) sb_pop(0, ia_if.__output);
    if (ib_if.__output[24] && ib_if._i_ready) sb_pop(1, ib_if.__output);
    if (ic_if.__output[24] && ic_if._i_ready) sb_pop(2, ic_if.__output);
  end

  task automatic wait_done(input int w, input int budget);
    for (int i = 0; i < budget && !done_of(w); i++) tick();
    check($sformatf("done_reached%0d", w), done_of(w), 1'b1);
  endtask

  task automatic rand_run(input int w, input int passes, input int n);
    push_run(w, passes, n);
    set_ready(w, 1'b0);
    pulse_start(w);
    for (int i = 0; i < 400 && !done_of(w); i++) begin
      set_ready(w, 1'($urandom_range(0, 1)));
      tick();
    end
    check($sformatf("rand_done%0d", w), done_of(w), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [25:0] o;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int w = 0; w < 3; w++) begin set_start(w, 1'b0); set_ready(w, 1'b0); end
    tick(); tick();
    check("reset_a", ia_if.__output, 26'd0);
    check("reset_b", ib_if.__output, 26'd0);
    check("reset_c", ic_if.__output, 26'd0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();

    // Basic run with one settle cycle after each accept.
    set_ready(0, 1'b1);
    push_run(0, RA, NA);
    pulse_start(0);
    for (int i = 0; i < NA * (HA + 1); i++) begin
      o = ia_if.__output;
      check("t1_valid_pattern", o[24], (i % (HA + 1)) == 0);
      check("t1_not_done", o[25], 1'b0);
      tick();
    end
    o = ia_if.__output;
    check("t1_done", o[25], 1'b1);
    check("t1_pass", o[23:16], RA);
    check("t1_valid_low", o[24], 1'b0);

    // Restart from DONE, then stall on variant 1.
    set_ready(0, 1'b0);
    push_run(0, RA, NA);
    pulse_start(0);
    o = ia_if.__output;
    check("t5_pass_clear", o[23:16], 0);
    check("t5_variant0", o[7:0], 0);
    check("t5_valid", o[24], 1'b1);
    check("t5_done_clear", o[25], 1'b0);
    set_ready(0, 1'b1);
    tick();
    set_ready(0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      o = ia_if.__output;
      check("t2_stall_valid", o[24], 1'b1);
      check("t2_stall_variant", o[7:0], 1);
      check("t2_stall_expected", o[15:8], 2);
      tick();
    end
    set_ready(0, 1'b1);
    wait_done(0, 20);

    // Reset while holding after variant 1.
    push_run(0, RA, NA);
    pulse_start(0);
    tick(); tick(); tick();
    o = ia_if.__output;
    check("t4_hold_valid", o[24], 1'b0);
    check("t4_hold_variant", o[7:0], 1);
    rst_a = 1'b1;
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    check("t4_reset_out", ia_if.__output, 26'd0);
    rst_a = 1'b0;
    qa.delete();
    tick();
    check("t4_idle_stays", ia_if.__output, 26'd0);
    push_run(0, RA, NA);
    pulse_start(0);
    o = ia_if.__output;
    check("t4_restart_variant", o[7:0], 0);
    check("t4_restart_valid", o[24], 1'b1);
    wait_done(0, 20);

    // Back-to-back emission over two passes.
    set_ready(1, 1'b1);
    push_run(1, RB, NB);
    pulse_start(1);
    for (int i = 0; i < RB * NB; i++) begin
      o = ib_if.__output;
      check("t3_valid", o[24], 1'b1);
      check("t3_variant", o[7:0], i % NB);
      tick();
    end
    o = ib_if.__output;
    check("t3_done", o[25], 1'b1);
    check("t3_pass", o[23:16], RB);
    check("t3_valid_low", o[24], 1'b0);

    // Randomised ready on both finite configurations.
    rand_run(0, RA, NA);
    rand_run(0, RA, NA);
    rand_run(1, RB, NB);
    rand_run(1, RB, NB);

    // Free-running single-variant config: pass_count wraps, done never rises.
    set_ready(2, 1'b1);
    push_run(2, 300, NC);
    pulse_start(2);
    for (int i = 0; i < 300; i++) begin
      o = ic_if.__output;
      check("t6_no_done", o[25], 1'b0);
      check("t6_pass", o[23:16], i % 256);
      tick();
    end
    set_ready(2, 1'b0);
    rst_c = 1'b1;
    tick();
    rst_c = 1'b0;

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
